// File: rtl/coder_pkg.sv
// Shared types and helpers for the coder lane packer.
package coder_pkg;

   localparam int LANES_DEF = 8;

   typedef logic [2:0] lane_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      TRAILER = 2'd2
   } state_t;

   // Byte mask for a partial word holding 'count' bytes (count 0 gives the trailer mask).
   function automatic logic [3:0] keep_from_count(input logic [1:0] count);
      case (count)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         2'd3:    return 4'b0111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/coder_lane_acc.sv
// One lane's byte accumulator: up to three buffered bytes plus a fill count.
// The fourth byte is consumed by the parent directly into its output word,
// so this block only clears itself when that happens.
module coder_lane_acc (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        clr,
   input  logic [7:0]  data,
   output logic [23:0] acc,
   output logic [1:0]  count,
   output logic        full_word
);

   // Accumulate bytes little-endian; unused bytes are kept at zero so a
   // partial word needs no further masking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
      end else if (clr) begin
         acc   <= '0;
         count <= '0;
      end else if (we) begin
         if (count == 2'd3) begin
            acc   <= '0;
            count <= '0;
         end else begin
            case (count)
               2'd0:    acc[7:0]   <= data;
               2'd1:    acc[15:8]  <= data;
               default: acc[23:16] <= data;
            endcase
            count <= count + 2'd1;
         end
      end
   end

   // The next byte written to this lane completes a 32-bit word.
   always_comb begin
      full_word = (count == 2'd3);
   end

endmodule

// File: rtl/coder_lane_packer.sv
// Packs the coder's (lane, byte, last) stream into lane-tagged 32-bit words.
// End of stream flushes partial words in lane order, then emits a trailer
// word carrying the stream byte count.
//
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid never depends on ready, data is held stable while valid && !ready,
// and in_ready is combinational from out_ready so the single output stage
// can refill in the same cycle it is drained.
module coder_lane_packer import coder_pkg::*; #(
   parameter int LANES = LANES_DEF,
   parameter int CNT_W = 32
) (
   input  logic        coder_clk,
   input  logic        coder_rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_idx,
   input  logic [7:0]  in_byte,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output lane_t       out_lane,
   output logic        out_last
);

   localparam int LW = $clog2(LANES);
   typedef logic [LW-1:0] idx_t;

   state_t           state;
   state_t           state_nx;
   idx_t             lane_sel;
   idx_t             flush_lane;
   logic [CNT_W-1:0] byte_cnt;

   logic [23:0]      acc_w [LANES];
   logic [1:0]       cnt_w [LANES];
   logic [LANES-1:0] full_w;
   logic [LANES-1:0] lane_we;
   logic [LANES-1:0] lane_clr;

   logic out_free;
   logic accept;
   logic flush_step;
   logic load_full;
   logic load_part;
   logic load_trl;
   logic unused_idx;

   assign lane_sel   = in_idx[LW-1:0];
   assign unused_idx = ^in_idx;
   assign out_free   = !out_valid || out_ready;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      coder_lane_acc u_acc (
         .clk       (coder_clk),
         .rst       (coder_rst),
         .we        (lane_we[g]),
         .clr       (lane_clr[g]),
         .data      (in_byte),
         .acc       (acc_w[g]),
         .count     (cnt_w[g]),
         .full_word (full_w[g])
      );
   end

   // State register.
   always_ff @(posedge coder_clk or posedge coder_rst) begin
      if (coder_rst) state <= RUN;
      else           state <= state_nx;
   end

   // Next state: FLUSH and TRAILER only advance while the output stage is free.
   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (accept && in_last) state_nx = FLUSH;
         FLUSH:   if (out_free && flush_lane == LW'(LANES - 1)) state_nx = TRAILER;
         TRAILER: if (out_free) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // Per-state controls: input acceptance, lane writes/clears and output loads.
   always_comb begin
      in_ready   = (state == RUN) && out_free && !coder_rst;
      accept     = in_valid && in_ready;
      flush_step = (state == FLUSH) && out_free;
      load_full  = accept && full_w[lane_sel];
      load_part  = flush_step && (cnt_w[flush_lane] != 2'd0);
      load_trl   = (state == TRAILER) && out_free;
      lane_we    = '0;
      lane_clr   = '0;
      if (accept)     lane_we[lane_sel]    = 1'b1;
      if (flush_step) lane_clr[flush_lane] = 1'b1;
   end

   // Output register, flush lane pointer and stream byte counter.
   always_ff @(posedge coder_clk or posedge coder_rst) begin
      if (coder_rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_lane   <= '0;
         out_last   <= 1'b0;
         flush_lane <= '0;
         byte_cnt   <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;

         if (load_full) begin
            out_valid <= 1'b1;
            out_data  <= {in_byte, acc_w[lane_sel]};
            out_keep  <= 4'b1111;
            out_lane  <= lane_t'(lane_sel);
            out_last  <= 1'b0;
         end else if (load_part) begin
            out_valid <= 1'b1;
            out_data  <= {8'h00, acc_w[flush_lane]};
            out_keep  <= keep_from_count(cnt_w[flush_lane]);
            out_lane  <= lane_t'(flush_lane);
            out_last  <= 1'b0;
         end else if (load_trl) begin
            out_valid <= 1'b1;
            out_data  <= 32'(byte_cnt);
            out_keep  <= 4'b0000;
            out_lane  <= '0;
            out_last  <= 1'b1;
         end

         if (accept && in_last) flush_lane <= '0;
         else if (flush_step)   flush_lane <= flush_lane + idx_t'(1);

         if (accept)        byte_cnt <= byte_cnt + CNT_W'(1);
         else if (load_trl) byte_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_coder_lane_packer.sv
// Bench for coder_lane_packer: directed stream scenarios plus a long random
// run, all output words compared against a byte-list reference model.
module tb_coder_lane_packer;

   localparam int LANES = 8;

   logic        coder_clk;
   logic        coder_rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_idx;
   logic [7:0]  in_byte;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic [2:0]  out_lane;
   logic        out_last;

   coder_lane_packer #(.LANES(LANES), .CNT_W(32)) dut (
      .coder_clk (coder_clk),
      .coder_rst (coder_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .in_byte   (in_byte),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_lane  (out_lane),
      .out_last  (out_last)
   );

   // ---------------- clock / reset ----------------
   initial coder_clk = 1'b0;
   always #5 coder_clk = ~coder_clk;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Expected word layout: {lane[2:0], keep[3:0], last, data[31:0]}
   logic [39:0] exp_q[$];
   int          lane_n [LANES];
   logic [7:0]  lane_b [LANES][4];
   logic [31:0] model_cnt;

   task automatic model_clear();
      for (int l = 0; l < LANES; l++) lane_n[l] = 0;
      model_cnt = '0;
      exp_q.delete();
   endtask

   task automatic model_byte(input int l, input logic [7:0] b, input bit last);
      logic [31:0] word;
      logic [3:0]  keep;
      model_cnt = model_cnt + 32'd1;
      lane_b[l][lane_n[l]] = b;
      lane_n[l]++;
      if (lane_n[l] == 4) begin
         word = {lane_b[l][3], lane_b[l][2], lane_b[l][1], lane_b[l][0]};
         exp_q.push_back({3'(l), 4'hf, 1'b0, word});
         lane_n[l] = 0;
      end
      if (last) begin
         for (int j = 0; j < LANES; j++) begin
            if (lane_n[j] > 0) begin
               word = '0;
               for (int i = 0; i < lane_n[j]; i++) word = word | (32'(lane_b[j][i]) << (8 * i));
               keep = 4'((1 << lane_n[j]) - 1);
               exp_q.push_back({3'(j), keep, 1'b0, word});
               lane_n[j] = 0;
            end
         end
         exp_q.push_back({3'd0, 4'd0, 1'b1, model_cnt});
         model_cnt = '0;
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [40:0] held;
   bit          hold;

   always @(negedge coder_clk) begin
      logic [39:0] obs;
      logic [39:0] expw;
      if (coder_rst) begin
         model_clear();
         hold = 1'b0;
      end else begin
         obs = {out_lane, out_keep, out_last, out_data};
         if (hold) check("stall_stable", {out_valid, obs}, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) expw = exp_q.pop_front();
            else                  expw = '1;
            check("out_word", obs, expw);
         end
         hold = out_valid && !out_ready;
         held = {out_valid, obs};
         if (in_valid && in_ready) model_byte(int'(in_idx[2:0]), in_byte, in_last);
      end
   end

   // ---------------- drivers ----------------
   bit rnd_ready = 1'b0;

   always @(posedge coder_clk) begin
      #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int l, input logic [7:0] b, input bit last);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_idx   = 8'(l) | (8'($urandom_range(0, 31)) << 3);
      in_byte  = b;
      in_last  = last;
      for (int k = 0; k < 1000 && !ok; k++) begin
         @(negedge coder_clk);
         if (in_ready) ok = 1'b1;
      end
      check("send_accept", ok, 1);
      @(posedge coder_clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge coder_clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int  first;
      bit  found;
      coder_rst = 1'b1;
      in_valid  = 1'b0;
      in_idx    = '0;
      in_byte   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      model_clear();

      // Reset state.
      repeat (2) @(negedge coder_clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_keep", out_keep, 0);
      check("rst_out_lane", out_lane, 0);
      check("rst_out_last", out_last, 0);
      check("rst_in_ready", in_ready, 0);
      next_cycle();
      coder_rst = 1'b0;
      next_cycle();

      // Two lanes with partial words at end of stream.
      send(0, 8'hAA, 0);
      send(5, 8'hBB, 0);
      send(0, 8'hCC, 1);
      repeat (12) next_cycle();

      // Eight bytes to lane 7: full words only, trailer after LANES+2 cycles.
      for (int i = 0; i < 8; i++) send(7, 8'($urandom_range(0, 255)), i == 7);
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge coder_clk);
         if (first == 0 && out_valid && out_last) first = k;
      end
      check("trailer_latency", first, 10);
      next_cycle();

      // One full word in lane 3, visible the cycle after the fourth byte.
      send(3, 8'h11, 0);
      send(3, 8'h22, 0);
      send(3, 8'h33, 0);
      send(3, 8'h44, 0);
      @(negedge coder_clk);
      check("word_valid", out_valid, 1);
      check("word_data", out_data, 32'h44332211);
      check("word_keep", out_keep, 4'hf);
      check("word_lane", out_lane, 3);
      next_cycle();

      // Reset with a partial lane-2 word and a stalled output word.
      send(2, 8'hE1, 0);
      send(2, 8'hE2, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 8'(8'h70 + i), 0);
      repeat (2) @(posedge coder_clk);
      #2;
      coder_rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_out_keep", out_keep, 0);
      next_cycle();
      coder_rst = 1'b0;
      out_ready = 1'b1;
      next_cycle();
      send(2, 8'h01, 0);
      send(2, 8'h02, 0);
      send(2, 8'h03, 0);
      send(2, 8'h04, 0);
      @(negedge coder_clk);
      check("postrst_data", out_data, 32'h04030201);
      check("postrst_lane", out_lane, 2);
      next_cycle();

      // Two consecutive streams; input blocked while the first trailer stalls.
      send(4, 8'h31, 0);
      send(4, 8'h32, 0);
      send(6, 8'h33, 1);
      out_ready = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         found     = out_valid && out_last;
         out_ready = out_valid && !out_last;
         if (!found) next_cycle();
      end
      check("trailer_reached", found, 1);
      in_valid = 1'b1;
      in_idx   = 8'd1;
      in_byte  = 8'h5A;
      for (int k = 0; k < 3; k++) begin
         @(negedge coder_clk);
         check("blocked_in_ready", in_ready, 0);
      end
      next_cycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge coder_clk);
      check("trailer_hs_in_ready", in_ready, 1);
      next_cycle();
      for (int i = 0; i < 5; i++) send($urandom_range(0, 7), 8'($urandom_range(0, 255)), i == 4);
      repeat (14) next_cycle();

      // Random lanes and bytes with random backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         if ($urandom_range(0, 3) == 0) next_cycle();
         send($urandom_range(0, 7), 8'($urandom_range(0, 255)), i == 4095);
      end
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge coder_clk);
      check("drain_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/coder_lane_packer.md
# coder_lane_packer

Downstream of the compressor's coder output port, in the coder clock domain. Consumes the byte stream (lane index, byte, last) and packs each lane's bytes into 32-bit little-endian words tagged with their lane. On end of stream it flushes partial words, then emits a trailer word carrying the total byte count. Its output feeds the host DMA/writeback path, replacing per-lane file sinks with one word stream.

## Interface
Parameters:
- LANES, 8: number of coder lanes; power of two; the lane field is log2(LANES) bits.
- CNT_W, 32: width of the stream byte counter carried in the trailer word.

Ports:
- coder_clk  in  1  block clock (coder domain).
- coder_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_idx  in  8  lane index; only [log2(LANES)-1:0] is used, upper bits ignored.
- in_byte  in  8  payload byte.
- in_last  in  1  final byte of the stream.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  packed word, or the byte count in the trailer.
- out_keep  out  4  valid-byte mask; 0000 marks the trailer.
- out_lane  out  3  lane of the word; 0 for the trailer.
- out_last  out  1  set only on the trailer.

## Operation
- Each lane holds a 24-bit accumulator plus a 2-bit fill count (0–3).
- The first byte of a word goes to [7:0]; later bytes go to [15:8], [23:16], [31:24].
- A 4th byte into a lane loads {byte, acc} into the output register with keep=1111 and clears that lane's count.
- Otherwise the byte is written into the accumulator and the count increments.
- byte_cnt (CNT_W bits) increments on every accepted byte and wraps modulo 2^CNT_W.
- in_ready = (state==RUN) && (!out_valid || out_ready) && !coder_rst. This is combinational from out_ready, which is intended.
- The output register is a single stage. It loads only when it is empty or being handshaken in the same cycle.
- States:
  - RUN:
    - Accepts bytes.
    - Accepting a byte with in_last=1 moves to FLUSH with flush_lane=0.
    - If that byte completes a word, the word is loaded that same cycle.
  - FLUSH, one lane per cycle, in lane order 0..LANES-1. Each cycle the output register is free:
    - If count(flush_lane)>0, load the partial word: data zero-padded in the upper bytes, keep = 0001/0011/0111 for count 1/2/3. Clear that lane.
    - Then advance. An empty lane advances without loading.
    - After lane LANES-1, go to TRAILER.
  - TRAILER:
    - When the output register is free, load data=byte_cnt, keep=0000, lane=0, last=1.
    - Clear byte_cnt and return to RUN.
    - New bytes are blocked until the trailer handshakes, because in_ready needs the register free.
- Simultaneous events:
  - A handshake and a new load in the same cycle are both legal.
  - out_valid stays 1 and the register takes the new word.
- Downstream backpressure holds FLUSH/TRAILER progress. Output data is stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_keep=0, out_lane=0, out_last=0.
  - in_ready=0 while coder_rst is high.
  - State RUN, all lane counts 0, byte_cnt 0.
- Reset mid-operation discards partial words and any pending output word. It does not produce a trailer.
- Latency: a word-completing byte accepted in cycle N gives out_valid=1 in cycle N+1.
- Flush duration, with out_ready held high:
  - Exactly LANES cycles in FLUSH, whether or not lanes are empty.
  - Then 1 cycle in TRAILER.
  - The trailer is visible in cycle N+LANES+2 after the in_last byte is accepted in cycle N.
- Throughput: 1 byte per cycle sustained when out_ready=1.

## Structure
- Package coder_pkg holds:
  - LANES_DEF, lane_t (logic [2:0]).
  - The state enum {RUN, FLUSH, TRAILER}.
  - The function keep_from_count(count) → 4-bit mask.
- Sub-module coder_lane_acc is one lane's accumulator and count, instantiated LANES times. Interface: write enable, byte, clear; outputs acc, count, and full_word.
- The top level holds the FSM, the output register and byte_cnt.

## Test plan
- Lane 3 receives bytes 11,22,33,44 and the 4th has no last → one word 0x44332211, keep 1111, lane 3, 1 cycle after the 4th byte. No trailer.
- Bytes AA (lane 0), BB (lane 5), CC (lane 0, last) → partial words lane 0 0x0000CCAA keep 0011, then lane 5 0x000000BB keep 0001, then trailer data=3 keep 0000 last=1.
- 8 bytes to lane 7, last on the 8th → two full words, no partial words, trailer data=8. Check the trailer appears 10 cycles after the last byte.
- Random out_ready (50%) over 4096 random-lane bytes → per-lane byte order is preserved, the count matches, and data is stable during stalls.
- Assert coder_rst mid-word (lane 2 count=2, output word pending) → outputs return to reset values. The next stream's first lane-2 word contains only new bytes.
- Two consecutive streams → the second trailer counts only second-stream bytes, and in_ready is 0 until the first trailer handshakes.
